plc_timer_core: RTL and testbench
=================================

# plc_timer_core

IEC 61131-3 style timer core (TON / TOF / TP) for one PLC timer channel. It sits directly downstream of the timer prescaler. It consumes the prescaler's one-cycle `PRESCALER_OV` tick as its time base and produces the elapsed-time value `ET` and timer output `Q` for the core's timer register file. Preset, mode and input bit come from the PLC core's timer registers.

## Interface
- `WIDTH`, 16: width of `TIMER_PT` and `ET`.
- `CLK`  in  1: clock.
- `CPU_Reset`  in  1: reset, asynchronous, active-high.
- `TIMER_EN`  in  1: channel enable; same signal that enables the prescaler.
- `PRESCALER_OV`  in  1: time-base tick, high for one `CLK` cycle per prescaler period.
- `TIMER_MODE`  in  2: timer mode.
  - 00: TON.
  - 01: TOF.
  - 10: TP.
  - 11: reserved.
- `TIMER_IN`  in  1: timer input bit (IEC `IN`).
- `TIMER_PT`  in  WIDTH: preset time in ticks (IEC `PT`).
- `IRQ_CLR`  in  1: clears `TIMER_IRQ`; ignored without `TIMER_IRQ_EN`.
- `Q`  out  1: timer output, registered.
- `ET`  out  WIDTH: elapsed ticks, registered, unsigned.
- `TIMER_IRQ`  out  1: sticky completion flag; constant 0 without `TIMER_IRQ_EN`.

## Operation
- Registers:
  - state: IDLE, HOLD, RUN, DONE.
  - latched mode `mode_q`.
  - `in_d`: previous `TIMER_IN`.
  - `ET`, `Q`, `TIMER_IRQ`.
- Reset values: all registers 0; state IDLE.
- `TIMER_EN`=0:
  - State, `ET`, `Q` and `TIMER_IRQ` hold.
  - `in_d` keeps tracking `TIMER_IN`, so edges that occur while disabled are lost.
  - `IRQ_CLR` still clears the flag.
- `mode_q` is loaded from `TIMER_MODE` only on a transition out of IDLE. Mode changes while not in IDLE are ignored until the channel returns to IDLE.
- Tick handling:
  - In RUN, a cycle with `PRESCALER_OV`=1 sets `ET` to `ET`+1.
  - Completion is detected when `ET`+1 ≥ `TIMER_PT` on a tick, or when `ET` ≥ `TIMER_PT` on any cycle (covers `PT` lowered mid-run).
  - On completion, `ET` is loaded with `TIMER_PT`. `ET` never exceeds `TIMER_PT` and never wraps.
- TON:
  - IDLE with `TIMER_IN`=1 → RUN, `ET`=0. If `PT`=0, go straight to DONE with `Q`=1.
  - RUN → DONE on completion, `Q`=1.
  - `TIMER_IN`=0 in RUN or DONE → IDLE, `ET`=0, `Q`=0.
- TOF:
  - IDLE with `TIMER_IN`=1 → HOLD, `Q`=1, `ET`=0.
  - HOLD with `TIMER_IN`=0 → RUN (`Q` stays 1). If `PT`=0, go to DONE with `Q`=0.
  - RUN with `TIMER_IN`=1 → HOLD, `ET`=0.
  - RUN → DONE on completion, `Q`=0.
  - DONE with `TIMER_IN`=1 → HOLD, `ET`=0, `Q`=1.
- TP:
  - IDLE with a rising edge (`TIMER_IN`=1, `in_d`=0) → RUN, `Q`=1, `ET`=0. If `PT`=0, go to DONE with `Q`=0 (no pulse).
  - Edges during RUN are ignored; `TIMER_IN` falling does not stop the pulse.
  - RUN → DONE on completion, `Q`=0.
  - DONE with `TIMER_IN`=0 → IDLE, `ET`=0.
- Reserved mode 11: stays in IDLE, `Q`=0, `ET`=0.
- Tick coincident with a state-exit condition: the exit wins and the tick is discarded.

## Timing
- All outputs are registered.
- Transitions take effect on the `CLK` edge after the triggering input.
- TON/TP with `PT`=N≥1: `Q` changes on the edge that samples the N-th `PRESCALER_OV` after entering RUN.
- `PT`=0: `Q` is final one cycle after the trigger.
- `CPU_Reset` mid-operation: outputs go to 0 immediately (asynchronous); the state machine restarts in IDLE.

## Configuration
- `TIMER_IRQ_EN` defined:
  - `TIMER_IRQ` is set on the cycle the state enters DONE via completion.
  - Cleared by `IRQ_CLR`=1; set wins when both occur in the same cycle.
- `TIMER_IRQ_EN` undefined: `TIMER_IRQ` is tied to 0, `IRQ_CLR` is unused, and no flag register exists.

## Test plan
- TON, `PT`=3, ticks every 4 cycles, `IN`=1: `ET` steps 0→1→2→3 on tick edges; `Q`=1 on the 3rd tick edge; `IN`=0 gives `Q`=0, `ET`=0 next cycle.
- TOF, `PT`=2: `IN`=1 gives `Q`=1 next cycle. `IN` falls, then after 2 ticks `Q`=0, `ET`=2. A repeat where `IN` rises after 1 tick gives `ET`=0 and `Q` stays 1.
- TP, `PT`=5: `IN` pulsed high for 1 cycle gives `Q`=1 for exactly 5 ticks. A second `IN` edge mid-pulse does not extend it. `ET` holds 5 while `IN`=1, then returns to 0.
- Boundaries:
  - `PT`=0 TON: `Q`=1 one cycle after `IN`.
  - `PT` lowered from 10 to 2 while `ET`=4: DONE next cycle, `ET`=2.
  - `TIMER_EN`=0 mid-run: `ET` frozen despite ticks.
- `CPU_Reset` asserted in RUN with `ET`=7: `Q`, `ET` and `TIMER_IRQ` are 0 asynchronously; after release, state is IDLE.
- With `TIMER_IRQ_EN`: `TIMER_IRQ` rises on DONE entry and stays until `IRQ_CLR`. Simultaneous completion and `IRQ_CLR` leaves it at 1. Without the macro it is always 0.

Source files
------------

// File: rtl/plc_timer_core.sv
// plc_timer_core: one IEC 61131-3 timer channel (TON / TOF / TP) driven by the prescaler tick.
// Optional sticky completion flag TIMER_IRQ is built only when TIMER_IRQ_EN is defined.
//
// state | meaning
// IDLE  | no timing in progress; Q=0, ET=0; mode follows TIMER_MODE
// HOLD  | TOF with input high; Q=1, ET held at 0
// RUN   | counting prescaler ticks towards TIMER_PT
// DONE  | ET reached TIMER_PT; Q at its final value for the latched mode
module plc_timer_core #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             CPU_Reset,
  input  logic             TIMER_EN,
  input  logic             PRESCALER_OV,
  input  logic [1:0]       TIMER_MODE,
  input  logic             TIMER_IN,
  input  logic [WIDTH-1:0] TIMER_PT,
  input  logic             IRQ_CLR,
  output logic             Q,
  output logic [WIDTH-1:0] ET,
  output logic             TIMER_IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_TON = 2'b00;
  localparam logic [1:0] MODE_TOF = 2'b01;
  localparam logic [1:0] MODE_TP  = 2'b10;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       mode_q;
  logic [1:0]       mode_nxt;
  logic             in_d;
  logic             q_nxt;
  logic [WIDTH-1:0] et_nxt;
  logic [WIDTH:0]   et_inc;
  logic             pt_zero;
  logic             in_rise;
  logic             done_hit;

  // One extra bit so ET+1 never wraps before the compare against PT.
  assign et_inc   = {1'b0, ET} + {{WIDTH{1'b0}}, 1'b1};
  assign pt_zero  = (TIMER_PT == '0);
  assign in_rise  = TIMER_IN & ~in_d;
  assign done_hit = (PRESCALER_OV && (et_inc >= {1'b0, TIMER_PT})) || (ET >= TIMER_PT);

  always_comb begin
    state_nxt = state;
    et_nxt    = ET;
    q_nxt     = Q;
    mode_nxt  = mode_q;

    case (state)
      ST_IDLE: begin
        et_nxt = '0;
        q_nxt  = 1'b0;
        case (TIMER_MODE)
          MODE_TON: begin
            if (TIMER_IN) begin
              if (pt_zero) begin
                state_nxt = ST_DONE;
                q_nxt     = 1'b1;
              end else begin
                state_nxt = ST_RUN;
              end
            end
          end
          MODE_TOF: begin
            if (TIMER_IN) begin
              state_nxt = ST_HOLD;
              q_nxt     = 1'b1;
            end
          end
          MODE_TP: begin
            if (in_rise) begin
              if (pt_zero) begin
                state_nxt = ST_DONE;
              end else begin
                state_nxt = ST_RUN;
                q_nxt     = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end

      ST_HOLD: begin
        et_nxt = '0;
        q_nxt  = 1'b1;
        if (!TIMER_IN) begin
          if (pt_zero) begin
            state_nxt = ST_DONE;
            q_nxt     = 1'b0;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end

      // Exit conditions are tested before done_hit/tick so a coincident tick is dropped.
      ST_RUN: begin
        case (mode_q)
          MODE_TON: begin
            if (!TIMER_IN) begin
              state_nxt = ST_IDLE;
              et_nxt    = '0;
              q_nxt     = 1'b0;
            end else if (done_hit) begin
              state_nxt = ST_DONE;
              et_nxt    = TIMER_PT;
              q_nxt     = 1'b1;
            end else if (PRESCALER_OV) begin
              et_nxt = et_inc[WIDTH-1:0];
            end
          end
          MODE_TOF: begin
            if (TIMER_IN) begin
              state_nxt = ST_HOLD;
              et_nxt    = '0;
              q_nxt     = 1'b1;
            end else if (done_hit) begin
              state_nxt = ST_DONE;
              et_nxt    = TIMER_PT;
              q_nxt     = 1'b0;
            end else if (PRESCALER_OV) begin
              et_nxt = et_inc[WIDTH-1:0];
            end
          end
          MODE_TP: begin
            if (done_hit) begin
              state_nxt = ST_DONE;
              et_nxt    = TIMER_PT;
              q_nxt     = 1'b0;
            end else if (PRESCALER_OV) begin
              et_nxt = et_inc[WIDTH-1:0];
            end
          end
          default: begin
            state_nxt = ST_IDLE;
            et_nxt    = '0;
            q_nxt     = 1'b0;
          end
        endcase
      end

      ST_DONE: begin
        case (mode_q)
          MODE_TON: begin
            if (!TIMER_IN) begin
              state_nxt = ST_IDLE;
              et_nxt    = '0;
              q_nxt     = 1'b0;
            end
          end
          MODE_TOF: begin
            if (TIMER_IN) begin
              state_nxt = ST_HOLD;
              et_nxt    = '0;
              q_nxt     = 1'b1;
            end
          end
          MODE_TP: begin
            if (!TIMER_IN) begin
              state_nxt = ST_IDLE;
              et_nxt    = '0;
              q_nxt     = 1'b0;
            end
          end
          default: begin
            state_nxt = ST_IDLE;
            et_nxt    = '0;
            q_nxt     = 1'b0;
          end
        endcase
      end

      default: begin
        state_nxt = ST_IDLE;
        et_nxt    = '0;
        q_nxt     = 1'b0;
      end
    endcase

    if ((state == ST_IDLE) && (state_nxt != ST_IDLE)) begin
      mode_nxt = TIMER_MODE;
    end
  end

  // in_d tracks the input even while disabled, so edges seen only while disabled are lost.
  always_ff @(posedge CLK or posedge CPU_Reset) begin
    if (CPU_Reset) begin
      state  <= ST_IDLE;
      mode_q <= 2'b00;
      in_d   <= 1'b0;
      ET     <= '0;
      Q      <= 1'b0;
    end else begin
      in_d <= TIMER_IN;
      if (TIMER_EN) begin
        state  <= state_nxt;
        mode_q <= mode_nxt;
        ET     <= et_nxt;
        Q      <= q_nxt;
      end
    end
  end

`ifdef TIMER_IRQ_EN
  logic irq_q;
  logic enter_done;

  assign enter_done = TIMER_EN && (state != ST_DONE) && (state_nxt == ST_DONE);

  // Set has priority over a same-cycle clear so a completion is never missed.
  always_ff @(posedge CLK or posedge CPU_Reset) begin
    if (CPU_Reset) begin
      irq_q <= 1'b0;
    end else if (enter_done) begin
      irq_q <= 1'b1;
    end else if (IRQ_CLR) begin
      irq_q <= 1'b0;
    end
  end

  assign TIMER_IRQ = irq_q;
`else
  logic unused_irq_clr;

  assign unused_irq_clr = IRQ_CLR;
  assign TIMER_IRQ      = 1'b0;
`endif

endmodule

// File: tb/tb_plc_timer_core.sv
// Bench for plc_timer_core: directed IEC timer scenarios plus randomized traffic,
// all checked every cycle against a behavioural timer model.
module tb_plc_timer_core;

  localparam int WIDTH  = 16;
  localparam int P_IDLE = 0;
  localparam int P_HOLD = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;

  logic             CLK = 1'b0;
  logic             CPU_Reset = 1'b1;
  logic             TIMER_EN = 1'b0;
  logic             PRESCALER_OV = 1'b0;
  logic [1:0]       TIMER_MODE = 2'b00;
  logic             TIMER_IN = 1'b0;
  logic [WIDTH-1:0] TIMER_PT = '0;
  logic             IRQ_CLR = 1'b0;
  logic             Q;
  logic [WIDTH-1:0] ET;
  logic             TIMER_IRQ;

  plc_timer_core #(.WIDTH(WIDTH)) dut (
    .CLK          (CLK),
    .CPU_Reset    (CPU_Reset),
    .TIMER_EN     (TIMER_EN),
    .PRESCALER_OV (PRESCALER_OV),
    .TIMER_MODE   (TIMER_MODE),
    .TIMER_IN     (TIMER_IN),
    .TIMER_PT     (TIMER_PT),
    .IRQ_CLR      (IRQ_CLR),
    .Q            (Q),
    .ET           (ET),
    .TIMER_IRQ    (TIMER_IRQ)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  int m_phase = P_IDLE;
  int m_mode  = 0;
  int m_et    = 0;
  bit m_q     = 1'b0;
  bit m_irq   = 1'b0;
  bit m_in_d  = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_mode  = 0;
    m_et    = 0;
    m_q     = 1'b0;
    m_irq   = 1'b0;
    m_in_d  = 1'b0;
  endtask

  // Advances the model across one rising edge using the currently driven inputs.
  task automatic model_step();
    int  pt;
    int  tick;
    int  adv_et;
    bit  reached;
    bit  tin;
    bit  rise;
    bit  was_done;
    pt       = int'(TIMER_PT);
    tin      = TIMER_IN;
    rise     = TIMER_IN && !m_in_d;
    tick     = PRESCALER_OV ? 1 : 0;
    was_done = (m_phase == P_DONE);
    // ET saturates at PT; reaching PT (by a tick or by PT dropping) is completion
    adv_et   = (m_et + tick < pt) ? m_et + tick : pt;
    reached  = (m_et + tick >= pt);
    if (TIMER_EN) begin
      if (m_phase == P_IDLE) m_mode = int'(TIMER_MODE);
      case (m_mode)
        0: begin
          if (!tin) begin
            m_phase = P_IDLE; m_et = 0; m_q = 1'b0;
          end else if (m_phase == P_IDLE) begin
            m_et = 0;
            if (pt == 0) begin m_phase = P_DONE; m_q = 1'b1; end
            else m_phase = P_RUN;
          end else if (m_phase == P_RUN) begin
            m_et = adv_et;
            if (reached) begin m_phase = P_DONE; m_q = 1'b1; end
          end
        end
        1: begin
          if (tin) begin
            if (m_phase != P_HOLD) begin m_phase = P_HOLD; m_et = 0; m_q = 1'b1; end
          end else if (m_phase == P_HOLD) begin
            if (pt == 0) begin m_phase = P_DONE; m_q = 1'b0; end
            else m_phase = P_RUN;
          end else if (m_phase == P_RUN) begin
            m_et = adv_et;
            if (reached) begin m_phase = P_DONE; m_q = 1'b0; end
          end
        end
        2: begin
          if (m_phase == P_IDLE) begin
            if (rise) begin
              m_et = 0;
              if (pt == 0) m_phase = P_DONE;
              else begin m_phase = P_RUN; m_q = 1'b1; end
            end
          end else if (m_phase == P_RUN) begin
            m_et = adv_et;
            if (reached) begin m_phase = P_DONE; m_q = 1'b0; end
          end else if (m_phase == P_DONE && !tin) begin
            m_phase = P_IDLE; m_et = 0;
          end
        end
        default: ;
      endcase
    end
`ifdef TIMER_IRQ_EN
    if (m_phase == P_DONE && !was_done) m_irq = 1'b1;
    else if (IRQ_CLR) m_irq = 1'b0;
`endif
    m_in_d = tin;
  endtask

  task automatic compare_all();
    chk("q", int'(Q), int'(m_q));
    chk("et", int'(ET), m_et);
    chk("irq", int'(TIMER_IRQ), int'(m_irq));
  endtask

  task automatic step(input bit en, input bit ov, input int md, input bit tin,
                      input int pt, input bit clr);
    TIMER_EN     = en;
    PRESCALER_OV = ov;
    TIMER_MODE   = 2'(md);
    TIMER_IN     = tin;
    TIMER_PT     = WIDTH'(pt);
    IRQ_CLR      = clr;
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  // Asserts reset between edges so the asynchronous clear is visible before any clock.
  task automatic do_reset();
    #2 CPU_Reset = 1'b1;
    #1;
    chk("rst_q", int'(Q), 0);
    chk("rst_et", int'(ET), 0);
    chk("rst_irq", int'(TIMER_IRQ), 0);
    model_reset();
    TIMER_EN = 1'b0; PRESCALER_OV = 1'b0; TIMER_IN = 1'b0; IRQ_CLR = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    CPU_Reset = 1'b0;
  endtask

  initial begin
    int md, pt;
    bit tin, ov, en, clr;

    @(negedge CLK);
    @(negedge CLK);
    CPU_Reset = 1'b0;
    compare_all();

    // TON, PT=3, tick every 4th cycle
    step(1, 0, 0, 1, 3, 0);
    for (int k = 1; k <= 12; k++) step(1, (k % 4) == 0, 0, 1, 3, 0);
    chk("ton_q_done", int'(Q), 1);
    chk("ton_et_done", int'(ET), 3);
    step(1, 0, 0, 0, 3, 0);
    chk("ton_q_drop", int'(Q), 0);

    // TOF, PT=2: complete, then re-trigger after one tick
    do_reset();
    step(1, 0, 1, 1, 2, 0);
    chk("tof_q_rise", int'(Q), 1);
    step(1, 0, 1, 0, 2, 0);
    step(1, 1, 1, 0, 2, 0);
    step(1, 1, 1, 0, 2, 0);
    chk("tof_q_off", int'(Q), 0);
    chk("tof_et_off", int'(ET), 2);
    step(1, 0, 1, 1, 2, 0);
    step(1, 0, 1, 0, 2, 0);
    step(1, 1, 1, 0, 2, 0);
    step(1, 0, 1, 1, 2, 0);
    chk("tof_et_retrig", int'(ET), 0);
    chk("tof_q_retrig", int'(Q), 1);

    // TP, PT=5, tick every 2nd cycle, extra edge mid-pulse, IN high at the end
    do_reset();
    step(1, 0, 2, 1, 5, 0);
    for (int k = 1; k <= 10; k++) begin
      step(1, (k % 2) == 0, 2, (k == 3) || (k >= 8), 5, 0);
      if (k == 8) chk("tp_q_mid", int'(Q), 1);
    end
    chk("tp_q_end", int'(Q), 0);
    chk("tp_et_end", int'(ET), 5);
    step(1, 1, 2, 1, 5, 0);
    step(1, 1, 2, 1, 5, 0);
    chk("tp_et_hold", int'(ET), 5);
    step(1, 0, 2, 0, 5, 0);
    chk("tp_et_idle", int'(ET), 0);

    // TON PT=0
    do_reset();
    step(1, 0, 0, 1, 0, 0);
    chk("ton_pt0_q", int'(Q), 1);

    // TON: freeze while disabled, then PT lowered 10 -> 2 at ET=4
    do_reset();
    step(1, 0, 0, 1, 10, 0);
    for (int k = 0; k < 3; k++) step(1, 1, 0, 1, 10, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 1, 10, 0);
    chk("en_freeze_et", int'(ET), 3);
    step(1, 1, 0, 1, 10, 0);
    chk("en_resume_et", int'(ET), 4);
    step(1, 0, 0, 1, 2, 0);
    chk("pt_lower_et", int'(ET), 2);
    chk("pt_lower_q", int'(Q), 1);

    // reset in RUN with ET=7
    do_reset();
    step(1, 0, 0, 1, 20, 0);
    for (int k = 0; k < 7; k++) step(1, 1, 0, 1, 20, 0);
    chk("pre_rst_et", int'(ET), 7);
    do_reset();
    step(1, 1, 0, 1, 20, 0);
    chk("post_rst_et", int'(ET), 0);

`ifdef TIMER_IRQ_EN
    do_reset();
    step(1, 0, 0, 1, 2, 0);
    step(1, 1, 0, 1, 2, 0);
    step(1, 1, 0, 1, 2, 0);
    chk("irq_set", int'(TIMER_IRQ), 1);
    step(1, 0, 0, 0, 2, 0);
    chk("irq_sticky", int'(TIMER_IRQ), 1);
    step(1, 0, 0, 0, 2, 1);
    chk("irq_clr", int'(TIMER_IRQ), 0);
    step(1, 0, 0, 1, 1, 0);
    step(1, 1, 0, 1, 1, 1);
    chk("irq_set_wins", int'(TIMER_IRQ), 1);
`else
    step(1, 1, 0, 1, 1, 0);
    step(1, 1, 0, 1, 1, 1);
    chk("irq_tied", int'(TIMER_IRQ), 0);
`endif

    // randomized traffic, including mid-run mode and PT changes
    for (int seg = 0; seg < 20; seg++) begin
      do_reset();
      md  = int'($urandom_range(3));
      pt  = int'($urandom_range(6));
      tin = 1'b0;
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(7) == 0) tin = !tin;
        ov  = ($urandom_range(2) == 0);
        en  = ($urandom_range(9) != 0);
        clr = ($urandom_range(7) == 0);
        if ($urandom_range(15) == 0) pt = int'($urandom_range(6));
        if ($urandom_range(31) == 0) md = int'($urandom_range(3));
        if ($urandom_range(199) == 0) do_reset();
        step(en, ov, md, tin, pt, clr);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
